// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings,
// shift-direction encoding and the frame counter width helper.
package usr_pkg;

    // Operation select encodings
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Direction of the most recent shift
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Frame counter must be able to hold the value WIDTH itself
    function automatic int frame_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/shift_frame_cnt.sv
// Frame tracker: counts consecutive same-direction shifts and pulses done
// for one cycle each time WIDTH shifts complete a frame.
module shift_frame_cnt
    import usr_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_en,
    input  logic shift_dir,
    input  logic load,
    output logic done
);

    localparam int CW = frame_cnt_width(WIDTH);
    localparam logic [CW-1:0] FRAME_LEN = CW'(WIDTH);
    localparam logic [CW-1:0] ONE       = CW'(1);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          dir_reg;
    logic          done_reg;

    // A zero count (after reset, load or a completed frame) or a direction
    // change starts a new frame with this shift counted as the first.
    always_comb begin
        cnt_next = cnt_reg + ONE;
        if ((cnt_reg == '0) || (shift_dir != dir_reg)) begin
            cnt_next = ONE;
        end
    end

    // Counter, direction flag and done pulse state
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg  <= '0;
            dir_reg  <= DIR_RIGHT;
            done_reg <= 1'b0;
        end else if (load) begin
            cnt_reg  <= '0;
            done_reg <= 1'b0;
        end else if (shift_en) begin
            dir_reg <= shift_dir;
            if (cnt_next == FRAME_LEN) begin
                cnt_reg  <= '0;
                done_reg <= 1'b1;
            end else begin
                cnt_reg  <= cnt_next;
                done_reg <= 1'b0;
            end
        end else begin
            done_reg <= 1'b0;
        end
    end

    assign done = done_reg;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left and parallel load,
// with serial outputs and a frame-completion pulse from shift_frame_cnt.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             si_r,
    input  logic             si_l,
    input  logic [WIDTH-1:0] pi,
    output logic [WIDTH-1:0] q,
    output logic             so_r,
    output logic             so_l,
    output logic             done
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] shr_val;
    logic [WIDTH-1:0] shl_val;
    logic             shift_en;
    logic             shift_dir;
    logic             load;

    // Per-bit neighbour selection for both shift directions
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == WIDTH - 1) begin : g_msb
                assign shr_val[gi] = si_r;
            end else begin : g_mid_r
                assign shr_val[gi] = q_reg[gi+1];
            end
            if (gi == 0) begin : g_lsb
                assign shl_val[gi] = si_l;
            end else begin : g_mid_l
                assign shl_val[gi] = q_reg[gi-1];
            end
        end
    endgenerate

    // Mode mux selecting the next register contents
    always_comb begin
        q_next = q_reg;
        case (mode)
            MODE_SHR:  q_next = shr_val;
            MODE_SHL:  q_next = shl_val;
            MODE_LOAD: q_next = pi;
            default:   q_next = q_reg;
        endcase
    end

    // Data register
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign shift_en  = (mode == MODE_SHR) || (mode == MODE_SHL);
    assign shift_dir = (mode == MODE_SHL) ? DIR_LEFT : DIR_RIGHT;
    assign load      = (mode == MODE_LOAD);

    shift_frame_cnt #(
        .WIDTH (WIDTH)
    ) u_frame_cnt (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (shift_en),
        .shift_dir (shift_dir),
        .load      (load),
        .done      (done)
    );

    assign q    = q_reg;
    assign so_r = q_reg[0];
    assign so_l = q_reg[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg at WIDTH=3 and WIDTH=8.
module tb_univ_shift_reg;
    import usr_pkg::*;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=3 instance
    logic       rst3  = 1'b1;
    logic [1:0] mode3 = MODE_HOLD;
    logic       sir3  = 1'b0;
    logic       sil3  = 1'b0;
    logic [2:0] pi3   = 3'b000;
    logic [2:0] q3;
    logic       sor3, sol3, done3;

    // WIDTH=8 instance
    logic       rst8  = 1'b1;
    logic [1:0] mode8 = MODE_HOLD;
    logic       sir8  = 1'b0;
    logic       sil8  = 1'b0;
    logic [7:0] pi8   = 8'h00;
    logic [7:0] q8;
    logic       sor8, sol8, done8;

    univ_shift_reg #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst3), .mode(mode3), .si_r(sir3), .si_l(sil3),
        .pi(pi3), .q(q3), .so_r(sor3), .so_l(sol3), .done(done3)
    );

    univ_shift_reg #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .mode(mode8), .si_r(sir8), .si_l(sil8),
        .pi(pi8), .q(q8), .so_r(sor8), .so_l(sol8), .done(done8)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle on the WIDTH=3 instance and sample 1 ns after the edge
    task automatic step3(input logic r, input logic [1:0] m, input logic sr,
                         input logic sl, input logic [2:0] p);
        rst3 = r; mode3 = m; sir3 = sr; sil3 = sl; pi3 = p;
        @(posedge clk);
        #1;
        $display("w3 rst=%0b mode=%02b si_r=%0b si_l=%0b pi=%03b -> q=%03b so_r=%0b so_l=%0b done=%0b",
                 r, m, sr, sl, p, q3, sor3, sol3, done3);
    endtask

    logic [7:0] exp8;
    int         last_done;

    initial begin
        // Reset
        step3(1, MODE_SHR, 1, 1, 3'b111);
        check("rst_q", q3, 3'b000);
        check("rst_done", done3, 0);
        check("rst_so_r", sor3, 0);
        check("rst_so_l", sol3, 0);

        // Right shifts 1,0,0
        step3(0, MODE_SHR, 1, 0, 0); check("shr1_q", q3, 3'b100); check("shr1_done", done3, 0);
        step3(0, MODE_SHR, 0, 0, 0); check("shr2_q", q3, 3'b010); check("shr2_done", done3, 0);
        step3(0, MODE_SHR, 0, 0, 0); check("shr3_q", q3, 3'b001); check("shr3_so_r", sor3, 1);
        check("shr3_done", done3, 1);
        step3(0, MODE_HOLD, 0, 0, 0); check("shr_hold_done", done3, 0); check("shr_hold_q", q3, 3'b001);

        // Load 101 then left shifts with si_l=0
        step3(0, MODE_LOAD, 0, 0, 3'b101); check("ld_q", q3, 3'b101); check("ld_so_l", sol3, 1);
        check("ld_done", done3, 0);
        step3(0, MODE_SHL, 0, 0, 0); check("shl1_q", q3, 3'b010); check("shl1_so_l", sol3, 0);
        check("shl1_done", done3, 0);
        step3(0, MODE_SHL, 0, 0, 0); check("shl2_q", q3, 3'b100); check("shl2_so_l", sol3, 1);
        check("shl2_done", done3, 0);
        step3(0, MODE_SHL, 0, 0, 0); check("shl3_q", q3, 3'b000); check("shl3_so_l", sol3, 0);
        check("shl3_done", done3, 1);
        step3(0, MODE_HOLD, 0, 0, 0); check("shl_hold_done", done3, 0);

        // Direction change restarts the frame
        step3(0, MODE_LOAD, 0, 0, 3'b000); check("dc_ld_done", done3, 0);
        step3(0, MODE_SHR, 0, 0, 0); check("dc_r1_done", done3, 0);
        step3(0, MODE_SHR, 0, 0, 0); check("dc_r2_done", done3, 0);
        step3(0, MODE_SHL, 0, 1, 0); check("dc_l1_done", done3, 0); check("dc_l1_q", q3, 3'b001);
        step3(0, MODE_SHL, 0, 1, 0); check("dc_l2_done", done3, 0);
        step3(0, MODE_SHL, 0, 1, 0); check("dc_l3_done", done3, 1); check("dc_l3_q", q3, 3'b111);
        step3(0, MODE_HOLD, 0, 0, 0); check("dc_hold_done", done3, 0);

        // Reset mid-frame discards partial count
        step3(0, MODE_SHR, 0, 0, 0); check("mr_r1_done", done3, 0);
        step3(0, MODE_SHR, 0, 0, 0); check("mr_r2_done", done3, 0);
        step3(1, MODE_SHR, 1, 0, 0); check("mr_rst_q", q3, 3'b000); check("mr_rst_done", done3, 0);
        step3(0, MODE_SHR, 0, 0, 0); check("mr_p1_done", done3, 0);
        step3(0, MODE_SHR, 0, 0, 0); check("mr_p2_done", done3, 0);
        step3(0, MODE_SHR, 0, 0, 0); check("mr_p3_done", done3, 1);

        // Hold keeps q and count; partial frame resumes afterwards
        step3(0, MODE_LOAD, 0, 0, 3'b101); check("hd_ld_q", q3, 3'b101);
        for (int i = 0; i < 5; i++) begin
            step3(0, MODE_HOLD, 1, 1, 3'b010);
            check("hd_q", q3, 3'b101);
            check("hd_done", done3, 0);
        end
        step3(0, MODE_SHR, 1, 0, 0); check("hd_r1_q", q3, 3'b110); check("hd_r1_done", done3, 0);
        step3(0, MODE_HOLD, 0, 0, 0); step3(0, MODE_HOLD, 0, 0, 0);
        check("hd_mid_q", q3, 3'b110);
        step3(0, MODE_SHR, 0, 0, 0); check("hd_r2_q", q3, 3'b011); check("hd_r2_done", done3, 0);
        step3(0, MODE_SHR, 0, 0, 0); check("hd_r3_q", q3, 3'b001); check("hd_r3_done", done3, 1);

        // WIDTH=8: 16 back-to-back right shifts
        @(negedge clk);
        rst8 = 1'b1; mode8 = MODE_HOLD;
        @(posedge clk); #1;
        check("w8_rst_q", q8, 8'h00);
        exp8 = 8'h00;
        last_done = -1;
        for (int i = 1; i <= 16; i++) begin
            rst8 = 1'b0; mode8 = MODE_SHR; sir8 = i[0] ^ i[2];
            exp8 = {sir8, exp8[7:1]};
            @(posedge clk); #1;
            $display("w8 shift=%0d si_r=%0b -> q=%08b done=%0b", i, sir8, q8, done8);
            check("w8_q", q8, exp8);
            check("w8_done", done8, (i == 8 || i == 16) ? 1'b1 : 1'b0);
            if (done8) begin
                if (last_done >= 0) check("w8_gap", 64'(i - last_done), 64'd8);
                last_done = i;
            end
        end
        mode8 = MODE_HOLD;
        @(posedge clk); #1;
        check("w8_end_done", done8, 0);
        check("w8_last_done", 64'(last_done), 64'd16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter: WIDTH, 3, register width in bits; legal range 2..64.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-005 Port: si_r  input  1  serial input for right shift; enters the MSB.
REQ-006 Port: si_l  input  1  serial input for left shift; enters the LSB.
REQ-007 Port: pi  input  WIDTH  parallel load data.
REQ-008 Port: q  output  WIDTH  register contents.
REQ-009 Port: so_r  output  1  right-shift serial output, equal to q[0].
REQ-010 Port: so_l  output  1  left-shift serial output, equal to q[WIDTH-1].
REQ-011 Port: done  output  1  one-cycle pulse marking completion of a WIDTH-shift frame.

Function
REQ-012 Hold (00) SHALL keep q, the frame counter and the last-direction flag unchanged and drive done=0.
REQ-013 Shift right (01) SHALL set q <= {si_r, q[WIDTH-1:1]} on each rising edge.
REQ-014 Shift left (10) SHALL set q <= {q[WIDTH-2:0], si_l} on each rising edge.
REQ-015 Load (11) SHALL set q <= pi, clear the frame counter to 0 and drive done=0 on the next cycle.
REQ-016 so_r and so_l SHALL be combinational decodes of the registered q, with no extra latency.
REQ-017 The frame counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL count shifts made since the last reset, load or direction change.
REQ-018 A shift in the same direction as the previous shift SHALL increment the counter.
REQ-019 A shift in the opposite direction to the previous shift SHALL set the counter to 1, so the current shift counts as the first of a new frame.
REQ-020 The first shift after a reset or a load SHALL count as 1, whatever the last-direction flag holds.
REQ-021 The shift that brings the counter to WIDTH SHALL register done=1 for exactly the following cycle and wrap the counter to 0.
REQ-022 Back-to-back frames SHALL produce done pulses exactly WIDTH cycles apart, with no dead cycle.
REQ-023 done SHALL be 0 in every cycle not covered by REQ-021.

Reset
REQ-024 When rst=1 at a rising edge: q=0, counter=0, last-direction flag=right, done=0.
REQ-025 Reset SHALL override every mode, and shifts applied during reset SHALL not be counted.
REQ-026 A reset mid-frame SHALL discard the partial count, so a full WIDTH shifts are needed afterwards.
REQ-027 After reset, so_r=0 and so_l=0.

Structure
REQ-028 Mode encodings SHALL be localparams MODE_HOLD, MODE_SHR, MODE_SHL and MODE_LOAD in the shared package usr_pkg, used by both RTL and bench.
REQ-029 The frame counter, direction flag and done pulse SHALL live in one sub-module, shift_frame_cnt, parameterised by WIDTH.
REQ-030 The data path (q and the mode mux) SHALL stay in univ_shift_reg, and all state SHALL be in a single clocked process per module.

Verification
REQ-031 WIDTH=3: reset, then mode=01 with si_r=1,0,0 -> q=100, 010, 001; so_r=1 after the third edge; done=1 for one cycle after the third shift.
REQ-032 WIDTH=3: load pi=101, then mode=10 with si_l=0 x3 -> q=010, 100, 000; so_l=1, 0, 1, 0 (after load and each shift); done pulses once after the third shift.
REQ-033 WIDTH=3: load 000; then 2 right shifts, 1 left shift, 2 more left shifts -> no done through the first left shift; done follows the third left shift.
REQ-034 WIDTH=3: 2 right shifts, then rst=1 for one cycle, then 3 right shifts -> q=000 and done=0 at reset; done only after the third post-reset shift.
REQ-035 WIDTH=3: q=101 with mode=00 for 5 cycles -> q stays 101, done=0, and the count resumes correctly afterwards.
REQ-036 WIDTH=8: 16 consecutive right shifts -> done pulses after shifts 8 and 16, exactly 8 cycles apart.
